// File: rtl/sel_scan_ctrl.sv
// sel_scan_ctrl: channel select sequencer feeding a 3-to-8 decoder.
// Auto-scans over the channels enabled by mask, giving each channel dwell+1
// cycles, or holds a manually loaded channel. All outputs come from flops.
//
// Ports:
//   clk1      rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        scan enable (low forces IDLE, highest priority)
//   mode      0 = auto-scan, 1 = manual hold
//   dwell     cycles per channel minus one, latched at each channel entry
//   mask      channel eligibility for auto-scan
//   load      manual load strobe (only honoured when mode = 1)
//   load_sel  channel index loaded by load
//   select    registered channel index
//   sel_valid registered, select addresses an active channel
//   wrap      registered one-cycle pulse when auto-scan wraps the ring
module sel_scan_ctrl #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk1,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    input  logic               load,
    input  logic [2:0]         load_sel,
    output logic [2:0]         select,
    output logic               sel_valid,
    output logic               wrap
);

    localparam int unsigned NCH = 8;
    localparam int unsigned IW  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_lat;

    logic [IW-1:0]      next_c;
    logic [IW-1:0]      lowest_c;
    logic               any_c;
    logic               expire_c;

    // First set mask bit strictly after cur, searching circularly; the search
    // ends on cur itself, so a single set bit maps back onto itself.
    function automatic logic [IW-1:0] next_after(input logic [IW-1:0] cur,
                                                 input logic [NCH-1:0] m);
        logic [IW-1:0] r;
        logic [IW-1:0] idx;
        logic          hit;
        r   = cur;
        hit = 1'b0;
        for (int i = 1; i <= int'(NCH); i++) begin
            idx = cur + IW'(i);
            if (!hit && m[idx]) begin
                r   = idx;
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    // Channel search and dwell expiry helpers
    always_comb begin
        next_c   = next_after(select, mask);
        lowest_c = next_after(IW'(NCH - 1), mask);
        any_c    = |mask;
        expire_c = (cnt == dwell_lat);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            select    <= '0;
            sel_valid <= 1'b0;
            wrap      <= 1'b0;
            cnt       <= '0;
            dwell_lat <= '0;
        end else begin
            wrap <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                select    <= '0;
                sel_valid <= 1'b0;
                cnt       <= '0;
            end else if (mode && load) begin
                // Manual load beats any pending expiry and suppresses wrap
                state     <= HOLD;
                select    <= load_sel;
                sel_valid <= 1'b1;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!mode) begin
                            state     <= SCAN;
                            select    <= any_c ? lowest_c : '0;
                            sel_valid <= any_c;
                            cnt       <= '0;
                            dwell_lat <= dwell;
                        end
                    end
                    SCAN: begin
                        if (!any_c) begin
                            // Freeze position and counter until a channel is eligible
                            sel_valid <= 1'b0;
                        end else if (expire_c) begin
                            select    <= next_c;
                            sel_valid <= 1'b1;
                            wrap      <= (next_c <= select);
                            cnt       <= '0;
                            dwell_lat <= dwell;
                        end else begin
                            sel_valid <= 1'b1;
                            cnt       <= cnt + DWELL_W'(1);
                        end
                    end
                    HOLD: begin
                        cnt <= '0;
                        if (!mode) begin
                            state     <= SCAN;
                            select    <= next_c;
                            sel_valid <= any_c;
                            dwell_lat <= dwell;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        select    <= '0;
                        sel_valid <= 1'b0;
                        cnt       <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Self-checking bench for sel_scan_ctrl: directed vector table plus
// hand-written reset sequences.
module tb_sel_scan_ctrl;

    logic       clk1;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [7:0] dwell;
    logic [7:0] mask;
    logic       load;
    logic [2:0] load_sel;
    logic [2:0] select;
    logic       sel_valid;
    logic       wrap;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic       en;
        logic       mode;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic       load;
        logic [2:0] lsel;
        logic [2:0] esel;
        logic       ev;
        logic       ew;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    sel_scan_ctrl #(.DWELL_W(8)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .dwell     (dwell),
        .mask      (mask),
        .load      (load),
        .load_sel  (load_sel),
        .select    (select),
        .sel_valid (sel_valid),
        .wrap      (wrap)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic add(input logic e, input logic m, input logic [7:0] mk,
                       input logic [7:0] dw, input logic ld, input logic [2:0] ls,
                       input logic [2:0] es, input logic ev, input logic ew,
                       input string tag);
        vec_t v;
        v.en = e; v.mode = m; v.mask = mk; v.dwell = dw; v.load = ld;
        v.lsel = ls; v.esel = es; v.ev = ev; v.ew = ew; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] es,
                         input logic ev, input logic ew);
        n_cmp++;
        if (select !== es || sel_valid !== ev || wrap !== ew) begin
            n_bad++;
            $display("FAIL %s: got select=%0d sel_valid=%0b wrap=%0b, want select=%0d sel_valid=%0b wrap=%0b",
                     name, select, sel_valid, wrap, es, ev, ew);
        end
    endtask

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; dwell = '0; mask = '0;
        load = 1'b0; load_sel = '0;

        // Full mask, dwell 0: one channel per cycle, wrap on return to 0
        for (int i = 0; i < 8; i++)
            add(1, 0, 8'hFF, 8'd0, 0, 0, 3'(i), 1, 0, "ff_step");
        add(1, 0, 8'hFF, 8'd0, 0, 0, 3'd0, 1, 1, "ff_wrap");
        add(1, 0, 8'hFF, 8'd0, 0, 0, 3'd1, 1, 0, "ff_after_wrap");
        add(0, 0, 8'hFF, 8'd0, 0, 0, 3'd0, 0, 0, "en_low_idle");
        // Sparse mask 1010_0100, dwell 2: 2,5,7,2 each held 3 cycles
        for (int i = 0; i < 3; i++) add(1, 0, 8'hA4, 8'd2, 0, 0, 3'd2, 1, 0, "sp_2");
        for (int i = 0; i < 3; i++) add(1, 0, 8'hA4, 8'd2, 0, 0, 3'd5, 1, 0, "sp_5");
        for (int i = 0; i < 3; i++) add(1, 0, 8'hA4, 8'd2, 0, 0, 3'd7, 1, 0, "sp_7");
        add(1, 0, 8'hA4, 8'd2, 0, 0, 3'd2, 1, 1, "sp_wrap2");
        add(1, 0, 8'hA4, 8'd2, 0, 0, 3'd2, 1, 0, "sp_2b");
        add(1, 0, 8'hA4, 8'd2, 0, 0, 3'd2, 1, 0, "sp_2c");
        for (int i = 0; i < 3; i++) add(1, 0, 8'hA4, 8'd2, 0, 0, 3'd5, 1, 0, "sp_5b");
        // Load on the expiry cycle of channel 5: load wins, no wrap
        add(1, 1, 8'hA4, 8'd2, 1, 3'd3, 3'd3, 1, 0, "load_at_expiry");
        add(1, 1, 8'hA4, 8'd2, 0, 3'd0, 3'd3, 1, 0, "hold_frozen");
        add(1, 0, 8'hA4, 8'd2, 0, 3'd0, 3'd5, 1, 0, "resume_after_3");
        add(1, 0, 8'hA4, 8'd2, 1, 3'd1, 3'd5, 1, 0, "load_mode0_ignored");
        add(1, 0, 8'hA4, 8'd2, 0, 3'd0, 3'd5, 1, 0, "resume_dwell");
        add(1, 0, 8'hA4, 8'd2, 0, 3'd0, 3'd7, 1, 0, "resume_next");
        // Mask cleared mid-scan, then single-bit mask
        add(1, 0, 8'h00, 8'd2, 0, 0, 3'd7, 0, 0, "mask0_a");
        add(1, 0, 8'h00, 8'd2, 0, 0, 3'd7, 0, 0, "mask0_b");
        add(1, 0, 8'h01, 8'd2, 0, 0, 3'd7, 1, 0, "mask1_cnt1");
        add(1, 0, 8'h01, 8'd2, 0, 0, 3'd7, 1, 0, "mask1_cnt2");
        add(1, 0, 8'h01, 8'd2, 0, 0, 3'd0, 1, 1, "mask1_wrap_a");
        add(1, 0, 8'h01, 8'd2, 0, 0, 3'd0, 1, 0, "mask1_hold1");
        add(1, 0, 8'h01, 8'd2, 0, 0, 3'd0, 1, 0, "mask1_hold2");
        add(1, 0, 8'h01, 8'd2, 0, 0, 3'd0, 1, 1, "mask1_wrap_b");
        // IDLE -> HOLD regardless of mask, and IDLE stays put without load
        add(0, 0, 8'h01, 8'd2, 0, 0, 3'd0, 0, 0, "idle_again");
        add(1, 1, 8'h00, 8'd2, 1, 3'd4, 3'd4, 1, 0, "idle_to_hold");
        add(1, 1, 8'h00, 8'd2, 0, 3'd0, 3'd4, 1, 0, "hold_keep");
        add(0, 1, 8'h00, 8'd2, 0, 3'd0, 3'd0, 0, 0, "hold_en_low");
        add(1, 1, 8'h00, 8'd2, 0, 3'd0, 3'd0, 0, 0, "idle_mode1_noload");

        #12;
        check("reset_state", 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            en = vecs[k].en; mode = vecs[k].mode; mask = vecs[k].mask;
            dwell = vecs[k].dwell; load = vecs[k].load; load_sel = vecs[k].lsel;
            tick();
            check($sformatf("%s[%0d]", vecs[k].tag, k), vecs[k].esel, vecs[k].ev, vecs[k].ew);
        end

        // Asynchronous reset while select = 6
        en = 1'b1; mode = 1'b0; mask = 8'hFF; dwell = 8'd0; load = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pre_reset_sel6", 3'd6, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", 3'd0, 1'b0, 1'b0);
        tick();
        check("reset_held", 3'd0, 1'b0, 1'b0);
        mask = 8'h30;
        #2;
        rst_n = 1'b1;
        tick();
        check("restart_lowest", 3'd4, 1'b1, 1'b0);
        tick();
        check("restart_next", 3'd5, 1'b1, 1'b0);
        tick();
        check("restart_wrap", 3'd4, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sel_scan_ctrl.md
SEL_SCAN_CTRL -- requirements
Module: sel_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 8, width of the dwell counter and of the dwell input.
REQ-002 clk1  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  scan enable; low forces IDLE.
REQ-005 mode  input  1  0 = auto-scan, 1 = manual hold.
REQ-006 dwell  input  DWELL_W  cycles per channel minus one; sampled at each channel entry.
REQ-007 mask  input  8  channel enable, bit k = channel k eligible for auto-scan.
REQ-008 load  input  1  manual load strobe, one cycle.
REQ-009 load_sel  input  3  channel loaded when load is high.
REQ-010 select  output  3  registered channel index, drives the 3-to-8 decoder select input.
REQ-011 sel_valid  output  1  registered; high when select addresses an active channel.
REQ-012 wrap  output  1  registered one-cycle pulse when auto-scan wraps round the channel ring.

Function
REQ-013 FSM states SHALL be IDLE, SCAN and HOLD, with a registered encoding.
REQ-014 In IDLE: select=0, sel_valid=0, wrap=0, dwell counter cleared.
REQ-015 IDLE->SCAN when en=1 and mode=0; select = lowest set bit of mask, next cycle.
REQ-016 IDLE->HOLD when en=1, mode=1 and load=1; select = load_sel.
REQ-017 en=0 in any state -> IDLE on the next edge; this has priority over all other events.
REQ-018 SCAN: the dwell counter loads 0 at channel entry and increments every cycle; it expires when count == dwell latched at entry.
REQ-019 dwell=0: channel advances every cycle; dwell=N: each channel is held N+1 cycles.
REQ-020 On expiry, select moves to the next set mask bit above the current index, searching circularly (7 -> 0).
REQ-021 wrap SHALL pulse for one cycle, coincident with the new select, when the new index is <= the old index.
REQ-022 Single set mask bit: select stays put; wrap pulses on every expiry.
REQ-023 mask=0 in SCAN: sel_valid=0, select holds, counter holds, no wrap; scanning resumes from the held index when any bit sets.
REQ-024 In SCAN, sel_valid=1 while mask[select]=1 or a next eligible channel exists; mask changes take effect at the next expiry.
REQ-025 SCAN/IDLE with mode=1 and load=1 -> HOLD with select=load_sel and sel_valid=1, regardless of mask.
REQ-026 HOLD: select frozen; a further load reloads select; wrap=0; counter held at 0.
REQ-027 HOLD with mode=0 -> SCAN; search starts at the next set bit after the held select, with a fresh dwell.
REQ-028 load in the same cycle as a dwell expiry: load wins and no wrap is issued.
REQ-029 load with mode=0 SHALL be ignored.
REQ-030 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE: select=0, sel_valid=0, wrap=0, dwell counter=0.
REQ-032 Deassertion takes effect synchronously; the first state change can occur on the first rising clk1 edge after rst_n is high.
REQ-033 Reset mid-scan or mid-hold SHALL discard all progress; no wrap pulse on reset entry or exit.

Verification
REQ-034 mask=8'hFF, dwell=0, en=1, mode=0: select steps 0,1..7,0 once per cycle; wrap is high only in the cycle select returns to 0.
REQ-035 mask=8'b1010_0100, dwell=2: select sequence 2,5,7,2, each held 3 cycles; wrap asserts with the return to 2.
REQ-036 Scanning at select=5, then mode=1, load=1, load_sel=3 in the cycle of expiry: select=3, HOLD, no wrap; mode=0 then resumes at the next set bit after 3.
REQ-037 mask driven to 0 mid-scan: sel_valid falls and select holds; restoring mask=8'h01 resumes, select=0, with a wrap pulse per expiry.
REQ-038 rst_n pulsed low between clock edges while select=6: outputs go to 0 immediately; after release with en=1, scan restarts at the lowest set mask bit.
